// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB register-bank completer.
// Holds the FSM state enum, bus widths, LFSR constants and the address-error rule.
package apb_slv_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  // Fibonacci LFSR taps 16,14,13,11 -> bit positions 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  function automatic logic apb_addr_err(input logic [ADDR_W-1:0] addr,
                                        input logic              write,
                                        input int unsigned       nregs);
    logic misaligned;
    logic out_of_range;
    logic id_write;
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = (32'(addr[7:2]) >= nregs);
    id_write     = write && (addr[7:2] == 6'd0);
    return misaligned || out_of_range || id_write;
  endfunction

endpackage

// File: rtl/apb_slv_if.sv
// APB bus bundle between the master and the register-bank completer.
// PCLK/PRESET stay as plain module ports.
interface apb_slv_if;
  import apb_slv_pkg::*;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [STRB_W-1:0] PSTRB;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_slv_lfsr.sv
// 16-bit Fibonacci LFSR used to randomise wait states; steps once per advance.
// Only instantiated when APB_SLV_RAND_WAIT_EN is defined.
module apb_slv_lfsr
  import apb_slv_pkg::*;
(
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        advance,
  output logic [15:0] value
);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      value <= LFSR_SEED;
    end else if (advance) begin
      value <= {value[14:0], ^(value & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/apb_slave_regbank.sv
// APB completer with a byte-strobed register file, fixed wait states and error responses.
// Optional macro APB_SLV_RAND_WAIT_EN: pseudo-random 0..WAIT_CYCLES waits from an LFSR.
module apb_slave_regbank
  import apb_slv_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 16,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic     PCLK,
  input  logic     PRESET,
  apb_slv_if.slave bus
);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        wait_load;
  logic              setup_ok;

  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] strb_q;
  logic              err_q;

  logic [ADDR_W-1:0] cur_addr;
  logic              cur_wr;
  logic              cur_err;
  logic [DATA_W-1:0] rd_val;

  logic [DATA_W-1:0] prdata_q;
  logic              pready_q;
  logic              pslverr_q;

  logic [DATA_W-1:0] regs [1:NUM_REGS-1];

  assign setup_ok = (state_q == IDLE) && bus.PSEL && !bus.PENABLE;

`ifdef APB_SLV_RAND_WAIT_EN
  logic [15:0] lfsr_val;

  apb_slv_lfsr u_lfsr (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .advance (setup_ok),
    .value   (lfsr_val)
  );

  assign wait_load = 4'(32'(lfsr_val[3:0]) % (WAIT_CYCLES + 1));
`else
  assign wait_load = 4'(WAIT_CYCLES);
`endif

  // Zero-wait transfers jump from IDLE straight to RESP, so the live bus
  // fields stand in for the not-yet-latched ones during the setup cycle.
  always_comb begin
    cur_addr = addr_q;
    cur_wr   = wr_q;
    cur_err  = err_q;
    if (state_q == IDLE) begin
      cur_addr = bus.PADDR;
      cur_wr   = bus.PWRITE;
      cur_err  = apb_addr_err(bus.PADDR, bus.PWRITE, NUM_REGS);
    end
  end

  always_comb begin
    rd_val = '0;
    if (cur_addr[7:2] == 6'd0) begin
      rd_val = ID_VALUE;
    end
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (cur_addr[7:2] == 6'(i)) begin
        rd_val = regs[i];
      end
    end
  end

  // cnt_q holds the access cycles still to go including the current one,
  // which lands PREADY exactly WAIT_CYCLES cycles after the first access cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (setup_ok) begin
          if (wait_load == 4'd0) begin
            state_d = RESP;
            cnt_d   = '0;
          end else begin
            state_d = ACCESS;
            cnt_d   = wait_load;
          end
        end
      end
      ACCESS: begin
        if (!bus.PSEL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (bus.PENABLE) begin
          if (cnt_q <= 4'd1) begin
            state_d = RESP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (setup_ok) begin
        addr_q  <= bus.PADDR;
        wr_q    <= bus.PWRITE;
        wdata_q <= bus.PWDATA;
        strb_q  <= bus.PSTRB;
        err_q   <= apb_addr_err(bus.PADDR, bus.PWRITE, NUM_REGS);
      end
      pready_q  <= (state_d == RESP);
      pslverr_q <= (state_d == RESP) && cur_err;
      prdata_q  <= ((state_d == RESP) && !cur_wr && !cur_err) ? rd_val : '0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if ((state_q == RESP) && wr_q && !err_q) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (addr_q[7:2] == 6'(i)) begin
          for (int unsigned b = 0; b < STRB_W; b++) begin
            if (strb_q[b]) begin
              regs[i][8*b +: 8] <= wdata_q[8*b +: 8];
            end
          end
        end
      end
    end
  end

  assign bus.PRDATA  = prdata_q;
  assign bus.PREADY  = pready_q;
  assign bus.PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Self-checking bench: a zero-wait and a one-wait completer driven by a simple APB master,
// compared against a behavioural register-file model.
module tb_apb_slave_regbank;
  import apb_slv_pkg::*;

  localparam logic [31:0] ID = 32'hA5B0_0001;
  localparam int NREGS = 16;

  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  always #5 PCLK = ~PCLK;

  apb_slv_if bus0();
  apb_slv_if bus1();

  apb_slave_regbank #(.NUM_REGS(16), .ID_VALUE(32'hA5B0_0001), .WAIT_CYCLES(0)) u_w0 (
    .PCLK(PCLK), .PRESET(PRESET), .bus(bus0)
  );
  apb_slave_regbank #(.NUM_REGS(16), .ID_VALUE(32'hA5B0_0001), .WAIT_CYCLES(1)) u_w1 (
    .PCLK(PCLK), .PRESET(PRESET), .bus(bus1)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [2][NREGS];

  task automatic drv(input int sel, input logic psel, input logic pen, input logic pwr,
                     input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    if (sel == 0) begin
      bus0.PSEL = psel; bus0.PENABLE = pen; bus0.PWRITE = pwr;
      bus0.PADDR = a; bus0.PWDATA = d; bus0.PSTRB = s;
    end else begin
      bus1.PSEL = psel; bus1.PENABLE = pen; bus1.PWRITE = pwr;
      bus1.PADDR = a; bus1.PWDATA = d; bus1.PSTRB = s;
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? bus0.PREADY : bus1.PREADY;
  endfunction
  function automatic logic [31:0] prd(input int sel);
    return (sel == 0) ? bus0.PRDATA : bus1.PRDATA;
  endfunction
  function automatic logic perr(input int sel);
    return (sel == 0) ? bus0.PSLVERR : bus1.PSLVERR;
  endfunction

  function automatic bit m_err(input logic [7:0] a, input bit wr);
    int idx;
    idx = int'(a) / 4;
    return (int'(a) % 4 != 0) || (idx >= NREGS) || (wr && idx == 0);
  endfunction

  task automatic m_access(input int sel, input bit wr, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] erd, output bit eer);
    int idx;
    idx = int'(a) / 4;
    eer = m_err(a, wr);
    erd = '0;
    if (!eer) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) mem[sel][idx][8*b +: 8] = d[8*b +: 8];
      end else begin
        erd = (idx == 0) ? ID : mem[sel][idx];
      end
    end
  endtask

  task automatic m_clear();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < NREGS; i++) mem[s][i] = '0;
  endtask

  // One APB transfer starting with its setup cycle now; returns in the cycle after PREADY.
  task automatic xfer(input int sel, input bit wr, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output bit er,
                      output int lat, output bit rn, output bit stray);
    rd = '0; er = 1'b0; lat = 0; rn = 1'b0; stray = 1'b0;
    drv(sel, 1'b1, 1'b0, wr, a, d, s);
    @(posedge PCLK); #1;
    drv(sel, 1'b1, 1'b1, wr, a, d, s);
    for (int c = 1; c <= 40; c++) begin
      @(negedge PCLK);
      if (rdy(sel)) begin
        lat = c; rd = prd(sel); er = perr(sel);
        break;
      end
      if (prd(sel) != '0 || perr(sel)) stray = 1'b1;
      @(posedge PCLK); #1;
    end
    @(posedge PCLK); #1;
    drv(sel, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    @(negedge PCLK);
    rn = rdy(sel);
    if (prd(sel) != '0 || perr(sel)) stray = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; bit er, rn, st; int lat;
    for (int s = 0; s < 2; s++) drv(s, 1'b1, 1'b0, 1'b1, 8'h04, 32'hFFFF_FFFF, 4'hF);
    @(posedge PCLK); #1;
    for (int s = 0; s < 2; s++) drv(s, 1'b1, 1'b1, 1'b1, 8'h04, 32'hFFFF_FFFF, 4'hF);
    PRESET = 1'b1;
    @(posedge PCLK); @(negedge PCLK);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if ({prd(s), rdy(s), perr(s)} !== 34'b0) begin
        errors++;
        $display("FAIL reset_outputs sel=%0d got prdata=%h pready=%b pslverr=%b expected all 0",
                 s, prd(s), rdy(s), perr(s));
      end
    end
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    for (int s = 0; s < 2; s++) drv(s, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    m_clear();
    @(negedge PCLK);
    for (int s = 0; s < 2; s++) begin
      xfer(s, 1'b0, 8'h04, 32'h0, 4'h0, rd, er, lat, rn, st);
      checks++;
      if (rd !== 32'h0 || er !== 1'b0 || lat != s + 1) begin
        errors++;
        $display("FAIL reset_read04 sel=%0d got rd=%h err=%b lat=%0d expected rd=0 err=0 lat=%0d",
                 s, rd, er, lat, s + 1);
      end
    end
  endtask

  task automatic test_full_write_read();
    logic [31:0] rd, erd; bit er, eer, rn, st; int lat;
    xfer(1, 1'b1, 8'h08, 32'hDEAD_BEEF, 4'hF, rd, er, lat, rn, st);
    m_access(1, 1'b1, 8'h08, 32'hDEAD_BEEF, 4'hF, erd, eer);
    checks++;
    if (lat != 2 || er !== 1'b0 || rn !== 1'b0 || st) begin
      errors++;
      $display("FAIL full_write got lat=%0d err=%b ready_after=%b stray=%b expected lat=2 err=0 ready_after=0 stray=0",
               lat, er, rn, st);
    end
    xfer(1, 1'b0, 8'h08, 32'h0, 4'h0, rd, er, lat, rn, st);
    checks++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || lat != 2) begin
      errors++;
      $display("FAIL full_readback got rd=%h err=%b lat=%0d expected rd=deadbeef err=0 lat=2", rd, er, lat);
    end
  endtask

  task automatic test_partial_strobe();
    logic [31:0] rd, erd; bit er, eer, rn, st; int lat;
    xfer(1, 1'b1, 8'h0C, 32'h1122_3344, 4'hF, rd, er, lat, rn, st);
    m_access(1, 1'b1, 8'h0C, 32'h1122_3344, 4'hF, erd, eer);
    xfer(1, 1'b1, 8'h0C, 32'hAABB_CCDD, 4'b0101, rd, er, lat, rn, st);
    m_access(1, 1'b1, 8'h0C, 32'hAABB_CCDD, 4'b0101, erd, eer);
    xfer(1, 1'b0, 8'h0C, 32'h0, 4'hF, rd, er, lat, rn, st);
    checks++;
    if (rd !== 32'h11BB_33DD || er !== 1'b0) begin
      errors++;
      $display("FAIL partial_strobe got rd=%h err=%b expected rd=11bb33dd err=0", rd, er);
    end
  endtask

  task automatic test_id();
    logic [31:0] rd; bit er, rn, st; int lat;
    for (int s = 0; s < 2; s++) begin
      xfer(s, 1'b0, 8'h00, 32'h0, 4'h0, rd, er, lat, rn, st);
      checks++;
      if (rd !== 32'hA5B0_0001 || er !== 1'b0) begin
        errors++;
        $display("FAIL id_read sel=%0d got rd=%h err=%b expected rd=a5b00001 err=0", s, rd, er);
      end
      xfer(s, 1'b1, 8'h00, 32'h1234_5678, 4'hF, rd, er, lat, rn, st);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0 || lat != s + 1) begin
        errors++;
        $display("FAIL id_write sel=%0d got err=%b rd=%h lat=%0d expected err=1 rd=0 lat=%0d",
                 s, er, rd, lat, s + 1);
      end
      xfer(s, 1'b0, 8'h00, 32'h0, 4'h0, rd, er, lat, rn, st);
      checks++;
      if (rd !== 32'hA5B0_0001) begin
        errors++;
        $display("FAIL id_unchanged sel=%0d got rd=%h expected rd=a5b00001", s, rd);
      end
    end
  endtask

  task automatic test_addr_errors();
    logic [7:0] addrs [3] = '{8'h41, 8'h40, 8'h7C};
    bit         wrs   [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] rd; bit er, rn, st; int lat;
    for (int k = 0; k < 3; k++) begin
      xfer(1, wrs[k], addrs[k], 32'hFFFF_FFFF, 4'hF, rd, er, lat, rn, st);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0 || lat != 2 || st) begin
        errors++;
        $display("FAIL addr_err a=%h wr=%b got err=%b rd=%h lat=%0d stray=%b expected err=1 rd=0 lat=2 stray=0",
                 addrs[k], wrs[k], er, rd, lat, st);
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd, erd; bit er, eer, rn, st, seen; int lat;
    drv(1, 1'b1, 1'b0, 1'b1, 8'h14, 32'h1234_5678, 4'hF);
    @(posedge PCLK); #1;
    drv(1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge PCLK);
      if (rdy(1)) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_pready got pready=1 expected pready=0");
    end
    xfer(1, 1'b0, 8'h14, 32'h0, 4'h0, rd, er, lat, rn, st);
    m_access(1, 1'b0, 8'h14, 32'h0, 4'h0, erd, eer);
    checks++;
    if (rd !== erd || er !== eer) begin
      errors++;
      $display("FAIL abort_no_write got rd=%h err=%b expected rd=%h err=%b", rd, er, erd, eer);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, erd, d; bit er, eer, rn, st; int lat;
    for (int k = 1; k <= 4; k++) begin
      d = $urandom;
      xfer(0, 1'b1, 8'(4 * k), d, 4'hF, rd, er, lat, rn, st);
      m_access(0, 1'b1, 8'(4 * k), d, 4'hF, erd, eer);
      checks++;
      if (lat != 1 || er !== 1'b0 || rn !== 1'b0 || st) begin
        errors++;
        $display("FAIL b2b_write k=%0d got lat=%0d err=%b ready_after=%b stray=%b expected lat=1 err=0 ready_after=0 stray=0",
                 k, lat, er, rn, st);
      end
    end
    for (int k = 1; k <= 4; k++) begin
      xfer(0, 1'b0, 8'(4 * k), 32'h0, 4'h0, rd, er, lat, rn, st);
      m_access(0, 1'b0, 8'(4 * k), 32'h0, 4'h0, erd, eer);
      checks++;
      if (rd !== erd || er !== 1'b0 || lat != 1) begin
        errors++;
        $display("FAIL b2b_read k=%0d got rd=%h err=%b lat=%0d expected rd=%h err=0 lat=1",
                 k, rd, er, lat, erd);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, d; logic [7:0] a; logic [3:0] s;
    bit er, eer, rn, st, wr; int lat, sel, r;
    for (int n = 0; n < 80; n++) begin
      sel = int'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      r   = int'($urandom_range(0, 9));
      if (r < 7) a = 8'($urandom_range(0, 15) * 4);
      else if (r < 9) a = 8'($urandom_range(0, 255));
      else a = 8'h00;
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      xfer(sel, wr, a, d, s, rd, er, lat, rn, st);
      m_access(sel, wr, a, d, s, erd, eer);
      checks++;
      if (rd !== erd || er !== eer || lat != sel + 1 || rn !== 1'b0 || st) begin
        errors++;
        $display("FAIL random n=%0d sel=%0d wr=%b a=%h got rd=%h err=%b lat=%0d ready_after=%b stray=%b expected rd=%h err=%b lat=%0d",
                 n, sel, wr, a, rd, er, lat, rn, st, erd, eer, sel + 1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int s = 0; s < 2; s++) drv(s, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    m_clear();
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    test_reset();
    test_full_write_read();
    test_partial_strobe();
    test_id();
    test_addr_errors();
    test_abort();
    test_back_to_back();
    test_random();
    @(posedge PCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
